// File: rtl/addrc_reader_if.sv
// Lane-load handshake and state bus for addrc_reader.
// A lane transfers on a rising edge where in_valid && in_ready; ld holds until ack is seen with ld high.
interface addrc_reader_if #(
    parameter int LANES  = 25,
    parameter int LANE_W = 64
);
    logic                      in_valid;
    logic [LANE_W-1:0]         in_lane;
    logic                      in_ready;
    logic                      ack;
    logic                      ld;
    logic [4:0]                lane_cnt;
    logic [LANES*LANE_W-1:0]   in_mem;
    logic                      fsm_state;

    modport slave (
        input  in_valid, in_lane, ack,
        output in_ready, ld, lane_cnt, in_mem, fsm_state
    );

    modport master (
        output in_valid, in_lane, ack,
        input  in_ready, ld, lane_cnt, in_mem, fsm_state
    );
endinterface

// File: rtl/addrc_reader.sv
// Gathers 25 serial Keccak lanes into 64 slice-major 25-bit words for the addRC XOR stage.
// Optional slice read port enabled by defining ADDRC_RD_PORT_EN.
module addrc_reader #(
    parameter int LANES  = 25,
    parameter int LANE_W = 64
) (
    input  logic          clk,
    input  logic          rst,
`ifdef ADDRC_RD_PORT_EN
    input  logic [5:0]    rd_idx,
    output logic [24:0]   rd_slice,
`endif
    addrc_reader_if.slave bus
);
    typedef enum logic {
        S_LOAD = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              accept;
    logic [LANES-1:0]  slice_q [LANE_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'(LANES - 1)) state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.ack) begin
                    state_d = S_LOAD;
                    cnt_d   = 5'd0;
                end
            end
            default: begin
                state_d = S_LOAD;
                cnt_d   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_LOAD;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lane k lands in bit k of every slice; cnt_q is at most LANES-1 while loading.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int z = 0; z < LANE_W; z++) slice_q[z] <= '0;
        end else if (accept) begin
            for (int z = 0; z < LANE_W; z++) slice_q[z][cnt_q] <= bus.in_lane[z];
        end
    end

    for (genvar j = 0; j < LANE_W; j++) begin : g_mem
        assign bus.in_mem[LANES*j +: LANES] = slice_q[j];
    end

    assign bus.ld        = (state_q == S_HOLD);
    assign bus.in_ready  = (state_q == S_LOAD);
    assign bus.lane_cnt  = cnt_q;
    assign bus.fsm_state = state_q;

`ifdef ADDRC_RD_PORT_EN
    assign rd_slice = slice_q[rd_idx];
`endif
endmodule

// File: tb/tb_addrc_reader.sv
// Randomized bench for addrc_reader against a lane-scatter reference model.
// Covers reset, directed single-bit/scatter loads, hold/ack, gapped loads with mid-load reset.
module tb_addrc_reader;
    localparam int LANES  = 25;
    localparam int LANE_W = 64;
    localparam int MEM_W  = LANES * LANE_W;

    logic clk;
    logic rst;
`ifdef ADDRC_RD_PORT_EN
    logic [5:0]  rd_idx;
    logic [24:0] rd_slice;
`endif

    addrc_reader_if #(.LANES(LANES), .LANE_W(LANE_W)) bus ();

    addrc_reader #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef ADDRC_RD_PORT_EN
        .rd_idx   (rd_idx),
        .rd_slice (rd_slice),
`endif
        .bus      (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [MEM_W-1:0] m_mem;
    int               m_cnt;
    logic             m_ld;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [MEM_W-1:0] got, input logic [MEM_W-1:0] exp);
        int first;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            first = -1;
            for (int i = 0; i < MEM_W; i++) if (first < 0 && got[i] !== exp[i]) first = i;
            $display("FAIL %s: got[63:0]=%h exp[63:0]=%h first diff bit %0d got=%b exp=%b",
                     tag, got[63:0], exp[63:0], first, got[first], exp[first]);
        end
    endtask

    // Apply one clock edge to DUT and model, then return at the following negedge.
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            m_mem = '0;
            m_cnt = 0;
            m_ld  = 1'b0;
        end else if (m_ld) begin
            if (bus.ack) begin
                m_ld  = 1'b0;
                m_cnt = 0;
            end
        end else if (bus.in_valid) begin
            for (int z = 0; z < LANE_W; z++) m_mem[LANES*z + m_cnt] = bus.in_lane[z];
            m_cnt++;
            if (m_cnt == LANES) m_ld = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ld"},       MEM_W'(bus.ld),       MEM_W'(m_ld));
        check({tag, ".cnt"},      MEM_W'(bus.lane_cnt), MEM_W'(m_cnt));
        check({tag, ".ready"},    MEM_W'(bus.in_ready), MEM_W'(!m_ld));
        check({tag, ".mem"},      bus.in_mem,           m_mem);
    endtask

    // driver: back-to-back load of the given lanes
    task automatic load_lanes(input logic [63:0] lanes [LANES], input string tag);
        for (int k = 0; k < LANES; k++) begin
            bus.in_valid = 1'b1;
            bus.in_lane  = lanes[k];
            step();
            check_all(tag);
        end
        bus.in_valid = 1'b0;
        bus.in_lane  = '0;
    endtask

    task automatic release_state(input string tag);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        check_all(tag);
    endtask

    logic [63:0]      lanes [LANES];
    logic [MEM_W-1:0] saved;
    logic [MEM_W-1:0] exp_c;
    int               budget;

    initial begin
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_lane  = {$urandom, $urandom};
        bus.ack      = 1'b0;
`ifdef ADDRC_RD_PORT_EN
        rd_idx       = '0;
`endif
        m_mem = 'x;
        m_cnt = 0;
        m_ld  = 1'b0;
        @(negedge clk);

        // reset with garbage on the inputs
        step();
        step();
        check("rst.mem",   bus.in_mem,              '0);
        check("rst.ld",    MEM_W'(bus.ld),          '0);
        check("rst.cnt",   MEM_W'(bus.lane_cnt),    '0);
        check("rst.ready", MEM_W'(bus.in_ready),    MEM_W'(1));
        check_all("rst");
        rst          = 1'b1;
        bus.in_valid = 1'b0;

        // single-bit load
        for (int k = 0; k < LANES; k++) lanes[k] = '0;
        lanes[0] = 64'h1;
        load_lanes(lanes, "single");
        check("single.ld",  MEM_W'(bus.ld),       MEM_W'(1));
        check("single.cnt", MEM_W'(bus.lane_cnt), MEM_W'(25));
        check("single.mem", bus.in_mem,           MEM_W'(1));
        release_state("single.rel");

        // scatter: lane 12 MSB lands in slice 63 bit 12
        for (int k = 0; k < LANES; k++) lanes[k] = '0;
        lanes[12] = 64'h8000000000000000;
        load_lanes(lanes, "scatter");
        exp_c = '0;
        exp_c[25*63 + 12] = 1'b1;
        check("scatter.mem", bus.in_mem, exp_c);
        release_state("scatter.rel");

        lanes[12] = 64'h0000000000008082;
        load_lanes(lanes, "scatter2");
        exp_c = '0;
        exp_c[25*1 + 12]  = 1'b1;
        exp_c[25*7 + 12]  = 1'b1;
        exp_c[25*15 + 12] = 1'b1;
        check("scatter2.mem", bus.in_mem, exp_c);

        // hold: input ignored, then ack
        saved = exp_c;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_lane  = '1;
            step();
            check("hold.mem",   bus.in_mem,            saved);
            check("hold.ready", MEM_W'(bus.in_ready),  '0);
            check_all("hold");
        end
        bus.in_valid = 1'b0;
        release_state("hold.rel");
        check("hold.rel.ld",  MEM_W'(bus.ld),       '0);
        check("hold.rel.cnt", MEM_W'(bus.lane_cnt), '0);
        check("hold.rel.mem", bus.in_mem,           saved);

        // gapped input with stray acks, reset after 10 lanes
        for (int i = 0; i < 40 && m_cnt < 10; i++) begin
            bus.in_valid = i[0];
            bus.in_lane  = {$urandom, $urandom};
            bus.ack      = 1'($urandom_range(0, 1));
            step();
            check_all("gap");
        end
        check("gap.cnt10", MEM_W'(bus.lane_cnt), MEM_W'(10));
        bus.ack = 1'b0;
        rst     = 1'b0;
        step();
        rst = 1'b1;
        check("gap.rst.mem", bus.in_mem,           '0);
        check("gap.rst.cnt", MEM_W'(bus.lane_cnt), '0);
        check_all("gap.rst");

        // random gapped full loads, with random release timing
        for (int r = 0; r < 3; r++) begin
            budget = 0;
            while (!m_ld && budget < 200) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_lane  = {$urandom, $urandom};
                bus.ack      = 1'($urandom_range(0, 1));
                step();
                check_all("rand");
                budget++;
            end
            bus.in_valid = 1'b0;
            bus.ack      = 1'b0;
            check("rand.done", MEM_W'(bus.ld), MEM_W'(1));
`ifdef ADDRC_RD_PORT_EN
            for (int i = 0; i < LANE_W; i++) begin
                rd_idx = 6'(i);
                #1;
                check("rd_slice", MEM_W'(rd_slice), MEM_W'(m_mem[25*i +: 25]));
            end
`endif
            release_state("rand.rel");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
